pipo_pingpong_ctrl: RTL and testbench
=====================================

Name: pipo_pingpong_ctrl

Overview:
- Control and status block for one ping-pong (PIPO) channel between a dataflow producer process and a consumer process.
- Tracks ownership of NUM_BUF buffer banks, issues bank selects, and generates the full/empty handshake flags.
- Keeps saturating blocked-cycle counters and sticky protocol-error flags, so deadlock and stall diagnosis can read per-channel state.
- Sits beside the bank memories; one instance per PIPO channel.

Parameters:
- NUM_BUF, 2, number of buffer banks; legal range 2..8.
- SEL_W, 3, width of bank-select and occupancy outputs; must satisfy 2^SEL_W > NUM_BUF.
- CNT_W, 16, width of stall counters.

Ports:
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst_n  in  1  synchronous active-low reset
- i_write  in  1  producer commits current write bank (one-cycle pulse)
- i_full_n  out  1  high = a free bank is available to producer
- i_buf_sel  out  SEL_W  bank index producer writes
- t_read  in  1  consumer releases current read bank (one-cycle pulse)
- t_empty_n  out  1  high = a committed bank is available to consumer
- t_buf_sel  out  SEL_W  bank index consumer reads
- occupancy  out  SEL_W  number of committed, unreleased banks (0..NUM_BUF)
- stat_clr  in  1  clears stall counters and error flags
- prod_blk_cnt  out  CNT_W  cycles the producer was blocked by full
- cons_blk_cnt  out  CNT_W  cycles the consumer was blocked by empty
- err_ovf  out  1  sticky: i_write seen while i_full_n=0
- err_udf  out  1  sticky: t_read seen while t_empty_n=0

Behaviour:
- Reset (ap_rst_n=0 at a clock edge):
  - Internal state: wptr=0, rptr=0, count=0, state EMPTY.
  - Outputs: i_full_n=1, t_empty_n=0, i_buf_sel=0, t_buf_sel=0, occupancy=0, counters=0, err_ovf=0, err_udf=0.
  - Reset mid-transfer discards all bank ownership. There is no partial recovery.
- State machine on count:
  - EMPTY (count=0), PARTIAL (0<count<NUM_BUF), FULL (count=NUM_BUF).
  - EMPTY->PARTIAL on an accepted write without a read.
  - PARTIAL->FULL when an accepted write without a read takes count to NUM_BUF.
  - PARTIAL->EMPTY when an accepted read without a write takes count to 0.
  - FULL->PARTIAL on an accepted read.
- Acceptance:
  - wr_acc = i_write & i_full_n; rd_acc = t_read & t_empty_n, both sampled on the registered flag values.
  - wr_acc: wptr advances by 1, and wraps NUM_BUF-1 -> 0 (no power-of-2 assumption).
  - rd_acc: rptr advances the same way.
  - Both accepted in the same cycle: both pointers advance, count unchanged, state unchanged. This is legal in every state. In FULL and EMPTY it cannot occur, because one flag is low.
- Flags:
  - i_full_n, t_empty_n and occupancy are registered and computed from next-state count.
  - Latency: one cycle from the accepting edge to the flag update.
  - i_buf_sel = wptr and t_buf_sel = rptr, registered, updating the same cycle as the flags.
- Illegal handshakes:
  - i_write while i_full_n=0 is ignored (no state change) and sets err_ovf.
  - t_read while t_empty_n=0 is ignored and sets err_udf.
  - Both flags hold until stat_clr or reset.
- Stall counters:
  - prod_blk_cnt increments when i_full_n=0 & t_read=0.
  - cons_blk_cnt increments when t_empty_n=0 & i_write=0.
  - Both saturate at 2^CNT_W-1 with no wrap.
- stat_clr:
  - Counters and error flags become 0 on the next edge.
  - stat_clr wins over a simultaneous increment or error set.
  - It does not affect pointers, count or handshake flags.

Test Plan:
- Reset, then idle 5 cycles -> i_full_n=1, t_empty_n=0, occupancy=0, cons_blk_cnt=5, prod_blk_cnt=0.
- NUM_BUF=2: two i_write pulses -> i_buf_sel 0->1->0, i_full_n=0 one cycle after 2nd write, occupancy=2; one t_read -> t_buf_sel=1, occupancy=1, i_full_n=1.
- NUM_BUF=3: 3 writes, 3 reads, 3 writes -> both pointers wrap 2->0 correctly, occupancy returns to 3, no err flags.
- PARTIAL (occupancy=1): simultaneous i_write & t_read for 10 cycles -> occupancy stays 1, both selects advance each cycle, no stall increments.
- FULL, i_write pulse -> err_ovf=1, occupancy unchanged; stat_clr -> err_ovf=0, prod_blk_cnt=0 next cycle.
- CNT_W=4, hold FULL 20 cycles -> prod_blk_cnt saturates at 15; assert ap_rst_n=0 mid-run -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/pipo_pingpong_ctrl.sv
// Ownership tracker for one ping-pong channel: hands out bank indices to producer
// and consumer, raises full/empty handshakes and keeps stall/error diagnostics.
module pipo_pingpong_ctrl #(
    parameter int NUM_BUF = 2,
    parameter int SEL_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             i_write,
    output logic             i_full_n,
    output logic [SEL_W-1:0] i_buf_sel,
    input  logic             t_read,
    output logic             t_empty_n,
    output logic [SEL_W-1:0] t_buf_sel,
    output logic [SEL_W-1:0] occupancy,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] prod_blk_cnt,
    output logic [CNT_W-1:0] cons_blk_cnt,
    output logic             err_ovf,
    output logic             err_udf
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_BUF - 1);
    localparam logic [SEL_W-1:0] NUM_BANKS = SEL_W'(NUM_BUF);
    localparam logic [SEL_W-1:0] ONE = SEL_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] wptr;
    logic [SEL_W-1:0] rptr;
    logic [SEL_W-1:0] count;
    logic [SEL_W-1:0] wptr_nxt;
    logic [SEL_W-1:0] rptr_nxt;
    logic [SEL_W-1:0] count_nxt;
    logic             wr_acc;
    logic             rd_acc;
    logic             prod_blocked;
    logic             cons_blocked;

    // Handshakes are judged against the registered flags the other side actually saw.
    assign wr_acc       = i_write & i_full_n;
    assign rd_acc       = t_read & t_empty_n;
    assign prod_blocked = ~i_full_n & ~t_read;
    assign cons_blocked = ~t_empty_n & ~i_write;

    always_comb begin
        wptr_nxt  = wptr;
        rptr_nxt  = rptr;
        count_nxt = count;
        state_nxt = state;

        if (wr_acc) begin
            wptr_nxt = (wptr == LAST_IDX) ? '0 : wptr + ONE;
        end
        if (rd_acc) begin
            rptr_nxt = (rptr == LAST_IDX) ? '0 : rptr + ONE;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + ONE;
            2'b01:   count_nxt = count - ONE;
            default: count_nxt = count;
        endcase

        case (state)
            ST_EMPTY: begin
                if (wr_acc && !rd_acc) begin
                    state_nxt = (count_nxt == NUM_BANKS) ? ST_FULL : ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (count_nxt == NUM_BANKS) begin
                    state_nxt = ST_FULL;
                end else if (count_nxt == '0) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (rd_acc && !wr_acc) begin
                    state_nxt = (count_nxt == '0) ? ST_EMPTY : ST_PARTIAL;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Flags and selects are registered from next-state values so they settle one
    // cycle after the accepting edge, together.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state     <= ST_EMPTY;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            i_full_n  <= 1'b1;
            t_empty_n <= 1'b0;
            occupancy <= '0;
        end else begin
            state     <= state_nxt;
            wptr      <= wptr_nxt;
            rptr      <= rptr_nxt;
            count     <= count_nxt;
            i_full_n  <= (count_nxt != NUM_BANKS);
            t_empty_n <= (count_nxt != '0);
            occupancy <= count_nxt;
        end
    end

    assign i_buf_sel = wptr;
    assign t_buf_sel = rptr;

    // Diagnostics: stat_clr takes priority over any increment or error set that cycle.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            prod_blk_cnt <= '0;
            cons_blk_cnt <= '0;
            err_ovf      <= 1'b0;
            err_udf      <= 1'b0;
        end else if (stat_clr) begin
            prod_blk_cnt <= '0;
            cons_blk_cnt <= '0;
            err_ovf      <= 1'b0;
            err_udf      <= 1'b0;
        end else begin
            if (prod_blocked && prod_blk_cnt != CNT_MAX) begin
                prod_blk_cnt <= prod_blk_cnt + 1'b1;
            end
            if (cons_blocked && cons_blk_cnt != CNT_MAX) begin
                cons_blk_cnt <= cons_blk_cnt + 1'b1;
            end
            if (i_write && !i_full_n) begin
                err_ovf <= 1'b1;
            end
            if (t_read && !t_empty_n) begin
                err_udf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipo_pingpong_ctrl.sv
// Bench for pipo_pingpong_ctrl: two instances (2 banks/16-bit counters and 3 banks/4-bit
// counters) share one stimulus stream and are compared against a transaction-count model.
module tb_pipo_pingpong_ctrl;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        i_write;
    logic        t_read;
    logic        stat_clr;

    logic        a_full_n, a_empty_n, a_ovf, a_udf;
    logic [2:0]  a_isel, a_tsel, a_occ;
    logic [15:0] a_pcnt, a_ccnt;

    logic        b_full_n, b_empty_n, b_ovf, b_udf;
    logic [2:0]  b_isel, b_tsel, b_occ;
    logic [3:0]  b_pcnt, b_ccnt;

    int total = 0;
    int bad = 0;

    always #5 ap_clk = ~ap_clk;

    pipo_pingpong_ctrl #(.NUM_BUF(2), .SEL_W(3), .CNT_W(16)) dut_a (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .i_write(i_write), .i_full_n(a_full_n), .i_buf_sel(a_isel),
        .t_read(t_read), .t_empty_n(a_empty_n), .t_buf_sel(a_tsel),
        .occupancy(a_occ), .stat_clr(stat_clr),
        .prod_blk_cnt(a_pcnt), .cons_blk_cnt(a_ccnt),
        .err_ovf(a_ovf), .err_udf(a_udf)
    );

    pipo_pingpong_ctrl #(.NUM_BUF(3), .SEL_W(3), .CNT_W(4)) dut_b (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .i_write(i_write), .i_full_n(b_full_n), .i_buf_sel(b_isel),
        .t_read(t_read), .t_empty_n(b_empty_n), .t_buf_sel(b_tsel),
        .occupancy(b_occ), .stat_clr(stat_clr),
        .prod_blk_cnt(b_pcnt), .cons_blk_cnt(b_ccnt),
        .err_ovf(b_ovf), .err_udf(b_udf)
    );

    // Reference: total accepted writes/reads; everything else follows arithmetically.
    typedef struct {
        int wr_tot;
        int rd_tot;
        int prod;
        int cons;
        bit ovf;
        bit udf;
    } model_t;

    model_t ma;
    model_t mb;

    function automatic model_t modelNext(model_t m, int nb, int cmax,
                                         bit w, bit r, bit clr, bit rst_n);
        model_t n;
        int occ;
        bit full_n;
        bit empty_n;
        n = m;
        occ = m.wr_tot - m.rd_tot;
        full_n = (occ != nb);
        empty_n = (occ != 0);
        if (!rst_n) begin
            n = '{default: 0};
            return n;
        end
        if (clr) begin
            n.prod = 0;
            n.cons = 0;
            n.ovf = 0;
            n.udf = 0;
        end else begin
            if (!full_n && !r && n.prod < cmax) n.prod++;
            if (!empty_n && !w && n.cons < cmax) n.cons++;
            if (w && !full_n) n.ovf = 1;
            if (r && !empty_n) n.udf = 1;
        end
        if (w && full_n) n.wr_tot++;
        if (r && empty_n) n.rd_tot++;
        return n;
    endfunction

    task automatic checkOutput(string name, int actual, int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkDut(string tag, model_t m, int nb,
                            logic full_n, logic empty_n, logic [2:0] isel, logic [2:0] tsel,
                            logic [2:0] occ, int pcnt, int ccnt, logic ovf, logic udf);
        int o;
        o = m.wr_tot - m.rd_tot;
        checkOutput({tag, "_full_n"}, int'(full_n), int'(o != nb));
        checkOutput({tag, "_empty_n"}, int'(empty_n), int'(o != 0));
        checkOutput({tag, "_i_buf_sel"}, int'(isel), m.wr_tot % nb);
        checkOutput({tag, "_t_buf_sel"}, int'(tsel), m.rd_tot % nb);
        checkOutput({tag, "_occupancy"}, int'(occ), o);
        checkOutput({tag, "_prod_blk"}, pcnt, m.prod);
        checkOutput({tag, "_cons_blk"}, ccnt, m.cons);
        checkOutput({tag, "_err_ovf"}, int'(ovf), int'(m.ovf));
        checkOutput({tag, "_err_udf"}, int'(udf), int'(m.udf));
    endtask

    // One clock: drive, advance both models across the edge, compare #1 later.
    task automatic applyStimulus(bit w, bit r, bit clr, bit rst_n);
        i_write = w;
        t_read = r;
        stat_clr = clr;
        ap_rst_n = rst_n;
        @(posedge ap_clk);
        ma = modelNext(ma, 2, 65535, w, r, clr, rst_n);
        mb = modelNext(mb, 3, 15, w, r, clr, rst_n);
        #1;
        checkDut("a", ma, 2, a_full_n, a_empty_n, a_isel, a_tsel, a_occ,
                 int'(a_pcnt), int'(a_ccnt), a_ovf, a_udf);
        checkDut("b", mb, 3, b_full_n, b_empty_n, b_isel, b_tsel, b_occ,
                 int'(b_pcnt), int'(b_ccnt), b_ovf, b_udf);
    endtask

    typedef struct {
        bit w;
        bit r;
        bit clr;
        bit full_n;
        bit empty_n;
        int isel;
        int tsel;
        int occ;
        bit ovf;
        bit udf;
    } vec_t;

    vec_t tbl[12];

    initial begin
        ma = '{default: 0};
        mb = '{default: 0};
        i_write = 0;
        t_read = 0;
        stat_clr = 0;
        ap_rst_n = 0;

        // Expected outputs of the two-bank instance after each edge.
        tbl[0]  = '{1, 0, 0, 1, 1, 1, 0, 1, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 1, 0, 0, 2, 0, 0};
        tbl[2]  = '{0, 1, 0, 1, 1, 0, 1, 1, 0, 0};
        tbl[3]  = '{1, 1, 0, 1, 1, 1, 0, 1, 0, 0};
        tbl[4]  = '{1, 0, 0, 0, 1, 0, 0, 2, 0, 0};
        tbl[5]  = '{1, 0, 0, 0, 1, 0, 0, 2, 1, 0};
        tbl[6]  = '{0, 0, 1, 0, 1, 0, 0, 2, 0, 0};
        tbl[7]  = '{0, 1, 0, 1, 1, 0, 1, 1, 0, 0};
        tbl[8]  = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 1};
        tbl[10] = '{1, 1, 1, 1, 1, 1, 0, 1, 0, 0};
        tbl[11] = '{0, 0, 0, 1, 1, 1, 0, 1, 0, 0};

        // Reset values, then five idle cycles of consumer starvation.
        applyStimulus(0, 0, 0, 0);
        checkOutput("rst_full_n", int'(a_full_n), 1);
        checkOutput("rst_empty_n", int'(a_empty_n), 0);
        checkOutput("rst_occ", int'(a_occ), 0);
        checkOutput("rst_cons_blk", int'(a_ccnt), 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1);
        checkOutput("idle_cons_blk", int'(a_ccnt), 5);
        checkOutput("idle_prod_blk", int'(a_pcnt), 0);
        checkOutput("idle_occ", int'(a_occ), 0);

        // Table-driven walk through the two-bank instance.
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].w, tbl[i].r, tbl[i].clr, 1);
            checkOutput($sformatf("tbl%0d_full_n", i), int'(a_full_n), int'(tbl[i].full_n));
            checkOutput($sformatf("tbl%0d_empty_n", i), int'(a_empty_n), int'(tbl[i].empty_n));
            checkOutput($sformatf("tbl%0d_isel", i), int'(a_isel), tbl[i].isel);
            checkOutput($sformatf("tbl%0d_tsel", i), int'(a_tsel), tbl[i].tsel);
            checkOutput($sformatf("tbl%0d_occ", i), int'(a_occ), tbl[i].occ);
            checkOutput($sformatf("tbl%0d_ovf", i), int'(a_ovf), int'(tbl[i].ovf));
            checkOutput($sformatf("tbl%0d_udf", i), int'(a_udf), int'(tbl[i].udf));
        end

        // Three-bank wrap: 3 writes, 3 reads, 3 writes.
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1);
        checkOutput("wrap_occ", int'(b_occ), 3);
        checkOutput("wrap_isel", int'(b_isel), 0);
        checkOutput("wrap_tsel", int'(b_tsel), 0);
        checkOutput("wrap_full_n", int'(b_full_n), 0);
        checkOutput("wrap_ovf", int'(b_ovf), 0);
        checkOutput("wrap_udf", int'(b_udf), 0);

        // Hold full long enough to saturate the 4-bit producer stall counter, then reset mid-run.
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 1);
        checkOutput("sat_prod_blk", int'(b_pcnt), 15);
        applyStimulus(0, 0, 0, 0);
        checkOutput("midrst_full_n", int'(b_full_n), 1);
        checkOutput("midrst_empty_n", int'(b_empty_n), 0);
        checkOutput("midrst_occ", int'(b_occ), 0);
        checkOutput("midrst_isel", int'(b_isel), 0);
        checkOutput("midrst_prod_blk", int'(b_pcnt), 0);

        // Simultaneous write/read in PARTIAL: occupancy steady, selects advance, no stalls.
        applyStimulus(1, 0, 0, 1);
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 1);
        checkOutput("sim_occ", int'(b_occ), 1);
        checkOutput("sim_isel", int'(b_isel), 2);
        checkOutput("sim_tsel", int'(b_tsel), 1);
        checkOutput("sim_prod_blk", int'(b_pcnt), 0);
        checkOutput("sim_cons_blk", int'(b_ccnt), 0);

        // Overflow while full, then stat_clr.
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("ovf_flag", int'(b_ovf), 1);
        checkOutput("ovf_occ", int'(b_occ), 3);
        applyStimulus(0, 0, 1, 1);
        checkOutput("clr_ovf", int'(b_ovf), 0);
        checkOutput("clr_prod_blk", int'(b_pcnt), 0);
        checkOutput("clr_occ", int'(b_occ), 3);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                          ($urandom_range(0, 29) == 0), ($urandom_range(0, 59) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
